// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator with replicated (clamped) edges for the median filter core.
// Two line buffers hold the previous two rows; one window is emitted per image pixel in raster order.
module median_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic [DW-1:0]            in_pixel,
    output logic                     out_valid,
    output logic [DW-1:0]            w0,
    output logic [DW-1:0]            w1,
    output logic [DW-1:0]            w2,
    output logic [DW-1:0]            w3,
    output logic [DW-1:0]            w4,
    output logic [DW-1:0]            w5,
    output logic [DW-1:0]            w6,
    output logic [DW-1:0]            w7,
    output logic [DW-1:0]            w8,
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y,
    output logic                     frame_done
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    typedef enum logic [2:0] {S_WAIT_SOF, S_FILL, S_RUN, S_EOL, S_FLUSH} state_t;
    typedef logic [2:0][DW-1:0] col_t;   // [0] top row, [1] middle row, [2] bottom row
    typedef logic [8:0][DW-1:0] win_t;

    state_t        state_q, state_d;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    col_t          prev_q, prev_d, prev2_q, prev2_d;
    win_t          win_q, win_d;
    logic [XW-1:0] wx_q, wx_d;
    logic [YW-1:0] wy_q, wy_d;
    logic          vld_q, vld_d, done_q, done_d, rdy_q, rdy_d;

    logic [DW-1:0] lb_a_q [IMG_W];   // row r-1
    logic [DW-1:0] lb_b_q [IMG_W];   // row r-2
    logic          lb_we, lb_dual;
    logic [XW-1:0] lb_addr;
    logic          xfer;
    col_t          new_col, fl_l, fl_c, fl_r;
    logic [XW-1:0] fl_li, fl_ri;

    function automatic win_t make_win(input col_t l, input col_t c, input col_t r);
        win_t w;
        for (int i = 0; i < 3; i++) begin
            w[3*i]   = l[i];
            w[3*i+1] = c[i];
            w[3*i+2] = r[i];
        end
        return w;
    endfunction

    assign xfer    = in_valid && rdy_q;
    assign new_col = {in_pixel, lb_a_q[col_q], lb_b_q[col_q]};

    // After the last row the bottom neighbour of row IMG_H-1 is itself, so lb_a feeds both lower rows.
    assign fl_li = (col_q == '0)    ? '0    : col_q - XW'(1);
    assign fl_ri = (col_q == X_MAX) ? X_MAX : col_q + XW'(1);
    assign fl_l  = {lb_a_q[fl_li], lb_a_q[fl_li], lb_b_q[fl_li]};
    assign fl_c  = {lb_a_q[col_q], lb_a_q[col_q], lb_b_q[col_q]};
    assign fl_r  = {lb_a_q[fl_ri], lb_a_q[fl_ri], lb_b_q[fl_ri]};

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        prev_d  = prev_q;
        prev2_d = prev2_q;
        win_d   = win_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        lb_we   = 1'b0;
        lb_dual = 1'b0;
        lb_addr = col_q;
        if (xfer && in_sof) begin
            lb_we   = 1'b1;
            lb_dual = 1'b1;
            lb_addr = '0;
            col_d   = XW'(1);
            row_d   = '0;
            state_d = S_FILL;
        end else begin
            unique case (state_q)
                S_WAIT_SOF: begin
                end
                // Row 0 goes into both buffers so the clamped row -1 reads back as row 0.
                S_FILL: begin
                    if (xfer) begin
                        lb_we   = 1'b1;
                        lb_dual = 1'b1;
                        if (col_q == X_MAX) begin
                            state_d = S_RUN;
                            col_d   = '0;
                            row_d   = YW'(1);
                        end else begin
                            col_d = col_q + XW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        lb_we  = 1'b1;
                        prev_d = new_col;
                        if (col_q == '0) begin
                            prev2_d = new_col;
                        end else begin
                            prev2_d = prev_q;
                            vld_d   = 1'b1;
                            win_d   = make_win(prev2_q, prev_q, new_col);
                            wx_d    = col_q - XW'(1);
                            wy_d    = row_q - YW'(1);
                        end
                        if (col_q == X_MAX) begin
                            state_d = S_EOL;
                            col_d   = '0;
                        end else begin
                            col_d = col_q + XW'(1);
                        end
                    end
                end
                S_EOL: begin
                    vld_d = 1'b1;
                    win_d = make_win(prev2_q, prev_q, prev_q);
                    wx_d  = X_MAX;
                    wy_d  = row_q - YW'(1);
                    if (row_q == Y_MAX) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_RUN;
                        row_d   = row_q + YW'(1);
                    end
                end
                S_FLUSH: begin
                    vld_d = 1'b1;
                    win_d = make_win(fl_l, fl_c, fl_r);
                    wx_d  = col_q;
                    wy_d  = Y_MAX;
                    if (col_q == X_MAX) begin
                        done_d  = 1'b1;
                        state_d = S_WAIT_SOF;
                        col_d   = '0;
                        row_d   = '0;
                    end else begin
                        col_d = col_q + XW'(1);
                    end
                end
                default: state_d = S_WAIT_SOF;
            endcase
        end
        rdy_d = (state_d != S_EOL) && (state_d != S_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_WAIT_SOF;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            wx_q    <= '0;
            wy_q    <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        prev_q  <= prev_d;
        prev2_q <= prev2_d;
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_b_q[lb_addr] <= lb_dual ? in_pixel : lb_a_q[lb_addr];
            lb_a_q[lb_addr] <= in_pixel;
        end
    end

    assign in_ready   = rdy_q;
    assign out_valid  = vld_q;
    assign frame_done = done_q;
    assign win_x      = wx_q;
    assign win_y      = wy_q;
    assign w0 = win_q[0];
    assign w1 = win_q[1];
    assign w2 = win_q[2];
    assign w3 = win_q[3];
    assign w4 = win_q[4];
    assign w5 = win_q[5];
    assign w6 = win_q[6];
    assign w7 = win_q[7];
    assign w8 = win_q[8];
endmodule

// File: tb/tb_median_window_gen.sv
// Scoreboard bench for median_window_gen on a 4x3 image: expected windows are queued at stimulus time
// and a negedge monitor pops and compares every presented window.
`timescale 1ns/1ps
module tb_median_window_gen;
    localparam int W = 4;
    localparam int H = 3;
    localparam logic [8:0][7:0] H00 = {8'd17, 8'd16, 8'd16, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
    localparam logic [8:0][7:0] H32 = {8'd35, 8'd35, 8'd34, 8'd35, 8'd35, 8'd34, 8'd19, 8'd19, 8'd18};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_pixel = 8'd0;
    logic       in_ready, out_valid, frame_done;
    logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
    logic [1:0] win_x, win_y;

    typedef struct packed {
        logic [8:0][7:0] w;
        logic [1:0]      x;
        logic [1:0]      y;
        logic            done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   st, lc;

    median_window_gen #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_pixel(in_pixel), .out_valid(out_valid),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8),
        .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int base, input int x, input int y);
        return 8'(base + 16 * y + x);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got == expv) passes++;
        else $display("FAIL %s got %0d expected %0d", name, got, expv);
    endtask

    task automatic push_windows(input int base, input int nwin, input bit hand);
        for (int i = 0; i < nwin; i++) begin
            exp_t e;
            int   cx;
            int   cy;
            cx = i % W;
            cy = i / W;
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++)
                    e.w[(dy + 1) * 3 + dx + 1] = pix(base, clampi(cx + dx, 0, W - 1), clampi(cy + dy, 0, H - 1));
            if (hand && i == 0) e.w = H00;
            if (hand && i == W * H - 1) e.w = H32;
            e.x    = 2'(cx);
            e.y    = 2'(cy);
            e.done = (i == W * H - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] p, input logic s, output int stall);
        stall = 0;
        @(negedge clk);
        while (!in_ready && stall < 50) begin
            stall++;
            @(negedge clk);
        end
        if (stall >= 50) begin
            checks++;
            $display("FAIL send_timeout in_ready low for %0d cycles, expected high", stall);
        end
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic run_frame(input int base, input bit toggle, input int nwin, input int npix,
                             input bit hand, output int stall_eol);
        int s;
        stall_eol = -1;
        push_windows(base, nwin, hand);
        for (int k = 0; k < npix; k++) begin
            if (toggle) @(negedge clk);
            send(pix(base, k % W, k / W), k == 0, s);
            if (k == 2 * W) stall_eol = s;
        end
    endtask

    task automatic wait_ready(output int lowcnt);
        lowcnt = 0;
        @(negedge clk);
        while (!in_ready && lowcnt < 1000) begin
            lowcnt++;
            @(negedge clk);
        end
    endtask

    task automatic drain_check(input string name);
        repeat (3) @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            exp_t g, e;
            g.w    = {w8, w7, w6, w5, w4, w3, w2, w1, w0};
            g.x    = win_x;
            g.y    = win_y;
            g.done = frame_done;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_window got x=%0d y=%0d w=%h, none expected", win_x, win_y, g.w);
            end else begin
                e = exp_q.pop_front();
                if (g === e) passes++;
                else $display("FAIL window got x=%0d y=%0d w=%h done=%b expected x=%0d y=%0d w=%h done=%b",
                              g.x, g.y, g.w, g.done, e.x, e.y, e.w, e.done);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, %0d windows still expected", exp_q.size());
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_window_zero", int'({w0, w1, w2, w3, w4, w5, w6, w7, w8} != 72'd0), 0);
        chk("rst_win_xy", int'({win_x, win_y}), 0);
        rst_n = 1'b1;

        // continuous frame
        run_frame(0, 1'b0, 12, 12, 1'b1, st);
        chk("eol_stall_cont", st, 1);
        wait_ready(lc);
        chk("flush_ready_low_cont", lc, 5);
        drain_check("queue_empty_cont");

        // alternate-cycle valid
        run_frame(0, 1'b1, 12, 12, 1'b0, st);
        chk("eol_stall_toggle", st, 0);
        wait_ready(lc);
        chk("flush_ready_low_toggle", lc, 5);
        drain_check("queue_empty_toggle");

        // pixels before any sof are dropped
        send(8'hEE, 1'b0, st);
        send(8'hEE, 1'b0, st);
        send(8'hEE, 1'b0, st);
        run_frame(0, 1'b0, 12, 12, 1'b1, st);
        wait_ready(lc);
        chk("flush_ready_low_presof", lc, 5);
        drain_check("queue_empty_presof");

        // abort at (2,1): only centre (0,0) of the old frame appears
        run_frame(0, 1'b0, 1, 6, 1'b0, st);
        run_frame(128, 1'b0, 12, 12, 1'b0, st);
        wait_ready(lc);
        chk("flush_ready_low_abort", lc, 5);
        drain_check("queue_empty_abort");

        // reset during FLUSH after centre (0,2) is presented
        run_frame(0, 1'b0, 9, 12, 1'b0, st);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midflush_rst_out_valid", out_valid, 0);
        chk("midflush_rst_in_ready", in_ready, 1);
        chk("midflush_rst_frame_done", frame_done, 0);
        chk("midflush_rst_window_zero", int'({w0, w1, w2, w3, w4, w5, w6, w7, w8} != 72'd0), 0);
        rst_n = 1'b1;
        chk("midflush_queue_empty", exp_q.size(), 0);
        run_frame(0, 1'b0, 12, 12, 1'b1, st);
        wait_ready(lc);
        chk("flush_ready_low_after_rst", lc, 5);
        drain_check("queue_empty_after_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
